// File: rtl/rv32i_types.sv
// Shared types and sizing for the instruction-side memory path.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_FILL
  } imem_resp_state_t;

  localparam int IMEM_BEAT_W    = 64;
  localparam int IMEM_BURST_LEN = 4;
  localparam int IMEM_LINE_W    = IMEM_BEAT_W * IMEM_BURST_LEN;
  localparam int IMEM_OFS_W     = $clog2(IMEM_LINE_W / 8);

  // A single-beat burst still needs a one-bit counter to keep widths legal.
  function automatic int imem_cnt_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/imem_fill_buffer.sv
// One-line instruction store: filled beat by beat from bmem, read a 32-bit word at a time.
module imem_fill_buffer
  import rv32i_types::*;
#(
  parameter int  BEAT_W    = IMEM_BEAT_W,
  parameter int  BURST_LEN = IMEM_BURST_LEN,
  localparam int LINE_W    = BEAT_W * BURST_LEN,
  localparam int OFS_W     = $clog2(LINE_W / 8),
  localparam int TAG_W     = 32 - OFS_W,
  localparam int WIDX_W    = OFS_W - 2,
  localparam int CNT_W     = imem_cnt_w(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start,
  input  logic              beat_we,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [WIDX_W-1:0] rd_idx,
  output logic [31:0]       rd_word,
  output logic [TAG_W-1:0]  line_tag,
  output logic              line_valid,
  output logic              last_beat
);

  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  beat_cnt;

  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign rd_word   = line_q[rd_idx * 32 +: 32];

  // The line is invalid for the whole burst so a partial line can never hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt   <= '0;
      line_valid <= 1'b0;
      line_tag   <= '0;
      line_q     <= '0;
    end else if (fill_start) begin
      beat_cnt   <= '0;
      line_valid <= 1'b0;
    end else if (beat_we) begin
      line_q[beat_cnt * BEAT_W +: BEAT_W] <= beat_data;
      if (last_beat) begin
        beat_cnt   <= '0;
        line_valid <= 1'b1;
        line_tag   <= fill_tag;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/imem_line_responder.sv
// Single-line instruction responder between fetch and the memory arbiter.
// Define IMEM_PERF_CNT_EN to add hit_count/miss_count performance outputs.
module imem_line_responder
  import rv32i_types::*;
#(
  parameter int BEAT_W    = IMEM_BEAT_W,
  parameter int BURST_LEN = IMEM_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [31:0]       imem_addr,
  input  logic [3:0]        imem_rmask,
  output logic              imem_resp,
  output logic [31:0]       imem_rdata,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int LINE_W = BEAT_W * BURST_LEN;
  localparam int OFS_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = 32 - OFS_W;
  localparam int WIDX_W = OFS_W - 2;

  imem_resp_state_t state, state_next;

  logic              req;
  logic              hit;
  logic              accept_hit;
  logic              take_miss;
  logic              grant;
  logic              beat_we;
  logic              last_beat;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [31:0]       rd_word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^imem_addr[1:0];

  assign req        = |imem_rmask;
  assign hit        = line_valid && (line_tag == imem_addr[31:OFS_W]);
  assign accept_hit = (state == IDLE) && req && hit;
  assign take_miss  = (state == IDLE) && req && !hit;
  assign grant      = (state == MISS_REQ) && bmem_ready;
  assign beat_we    = (state == MISS_FILL) && bmem_rvalid;

  imem_fill_buffer #(
    .BEAT_W    (BEAT_W),
    .BURST_LEN (BURST_LEN)
  ) u_fill_buffer (
    .clk        (clk),
    .rst        (rst),
    .fill_start (grant),
    .beat_we    (beat_we),
    .beat_data  (bmem_rdata),
    .fill_tag   (bmem_addr[31:OFS_W]),
    .rd_idx     (imem_addr[OFS_W-1:2]),
    .rd_word    (rd_word),
    .line_tag   (line_tag),
    .line_valid (line_valid),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // After the last beat we always return to IDLE and re-look-up whatever
  // address fetch is presenting then, which covers the post-flush case.
  always_comb begin
    state_next = state;
    bmem_read  = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_miss) state_next = MISS_REQ;
      end
      MISS_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) state_next = MISS_FILL;
      end
      MISS_FILL: begin
        if (beat_we && last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The miss address is captured once so a flush cannot retarget a burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           bmem_addr <= '0;
    else if (take_miss) bmem_addr <= {imem_addr[31:OFS_W], {OFS_W{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
    end else begin
      imem_resp <= accept_hit && !flush;
      if (accept_hit) imem_rdata <= rd_word;
    end
  end

`ifdef IMEM_PERF_CNT_EN
  // Hits are counted at acceptance, so flushed-away hits are included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept_hit) hit_count  <= hit_count + 32'd1;
      if (take_miss)  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_line_responder.sv
// Scoreboard bench for imem_line_responder: fetch requester, bmem burst responder, line model.
module tb_imem_line_responder;

  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [31:0]       imem_addr;
  logic [3:0]        imem_rmask;
  logic              imem_resp;
  logic [31:0]       imem_rdata;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_ready;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
`endif

  imem_line_responder #(
    .BEAT_W    (BEAT_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
`ifdef IMEM_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int read_cycles = 0;
  int last_beat_cyc = 0;
  int grant_delay = 2;
  int beat_limit = BURST_LEN;
  int flush_beat = -1;
  logic [31:0] flush_addr = '0;
  logic        model_valid = 1'b0;
  logic [26:0] model_tag = '0;
  int model_hits = 0;
  int model_misses = 0;
  logic [31:0] exp_word_q[$];
  logic [31:0] exp_bmem_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Backing memory: line 0x60000000 carries the 0x1111..0x4444 beats, others are address-derived.
  function automatic logic [63:0] mem_beat(input logic [31:0] line, input int k);
    logic [31:0] lo;
    if (line == 32'h6000_0000) begin
      lo = 32'(k + 1) * 32'h0000_1111;
      return {32'hBEEF_0000 | lo, lo};
    end
    return {line ^ 32'(8 * k + 4) ^ 32'hC0DE_0000, line ^ 32'(8 * k) ^ 32'h0F0F_0000};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [63:0] b;
    int wi;
    wi = int'(addr[4:2]);
    b  = mem_beat({addr[31:5], 5'b0}, wi / 2);
    return (wi % 2 == 1) ? b[63:32] : b[31:0];
  endfunction

  task automatic modelRequest(input logic [31:0] addr, input bit want_resp);
    if (!(model_valid && model_tag == addr[31:5])) begin
      exp_bmem_q.push_back({addr[31:5], 5'b0});
      model_valid = 1'b1;
      model_tag   = addr[31:5];
      model_misses++;
    end
    if (want_resp) begin
      exp_word_q.push_back(exp_word(addr));
      model_hits++;
    end
  endtask

  // Called at the first negedge where bmem_read is seen.
  task automatic serveBurst();
    logic [31:0] line;
    if (exp_bmem_q.size() == 0) begin
      checkOutput("bmem_read_unexpected", {31'b0, bmem_read}, 32'd0);
      line = bmem_addr;
    end else begin
      line = exp_bmem_q.pop_front();
      checkOutput("bmem_addr", bmem_addr, line);
    end
    repeat (grant_delay) begin
      @(negedge clk);
      checkOutput("bmem_read_held", {31'b0, bmem_read}, 32'd1);
    end
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0;
    for (int k = 0; k < beat_limit; k++) begin
      bmem_rvalid   = 1'b1;
      bmem_rdata    = mem_beat(line, k);
      last_beat_cyc = cyc;
      if (k == flush_beat) begin
        flush      = 1'b1;
        imem_addr  = flush_addr;
        modelRequest(flush_addr, 1'b1);
        flush_beat = -1;
      end
      @(negedge clk);
      flush = 1'b0;
    end
    bmem_rvalid = 1'b0;
  endtask

  task automatic waitResp(output int lat);
    int start;
    start = cyc;
    forever begin
      @(negedge clk);
      if (imem_resp) begin
        lat = cyc - start;
        return;
      end
      if (bmem_read) serveBurst();
      if (cyc - start > 300) begin
        checkOutput("resp_timeout", 32'd0, 32'd1);
        lat = -1;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] rmask, output int lat);
    modelRequest(addr, 1'b1);
    imem_addr  = addr;
    imem_rmask = rmask;
    waitResp(lat);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: every imem_resp must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (bmem_read) read_cycles++;
    if (imem_resp) begin
      if (exp_word_q.size() == 0) checkOutput("resp_spurious", 32'd1, 32'd0);
      else                        checkOutput("rdata", imem_rdata, exp_word_q.pop_front());
    end
  end

  initial begin
    int lat;
    int rc;
    int w;
    rst         = 1'b0;
    flush       = 1'b0;
    imem_addr   = '0;
    imem_rmask  = '0;
    bmem_ready  = 1'b0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_imem_resp",  {31'b0, imem_resp}, 32'd0);
    checkOutput("rst_imem_rdata", imem_rdata, 32'd0);
    checkOutput("rst_bmem_read",  {31'b0, bmem_read}, 32'd0);
    checkOutput("rst_bmem_addr",  bmem_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("resp_after_release", {31'b0, imem_resp}, 32'd0);

    $display("[TB] cold miss");
    grant_delay = 2;
    applyStimulus(32'h6000_0000, 4'hF, lat);
    checkOutput("miss_tail_latency", 32'(cyc - last_beat_cyc), 32'd2);

    $display("[TB] streaming hits");
    rc = read_cycles;
    for (int i = 1; i < 8; i++) begin
      applyStimulus(32'h6000_0000 + 32'(4 * i + (i % 4)), 4'((i % 15) + 1), lat);
      checkOutput("hit_latency", 32'(lat), 32'd1);
    end
    checkOutput("stream_no_bmem", 32'(read_cycles - rc), 32'd0);

    $display("[TB] flush on hit");
    imem_addr = 32'h6000_0008;
    flush     = 1'b1;
    model_hits++;
    @(negedge clk);
    checkOutput("flush_hit_noresp", {31'b0, imem_resp}, 32'd0);
    flush = 1'b0;
    applyStimulus(32'h6000_000C, 4'h8, lat);
    checkOutput("post_flush_latency", 32'(lat), 32'd1);

    $display("[TB] line crossing");
    applyStimulus(32'h6000_001C, 4'hF, lat);
    checkOutput("cross_hit_latency", 32'(lat), 32'd1);
    grant_delay = 0;
    applyStimulus(32'h6000_0020, 4'h1, lat);
    imem_rmask = 4'h0;
    repeat (3) @(negedge clk);

    $display("[TB] flush mid-fill");
    grant_delay = 1;
    flush_beat  = 2;
    flush_addr  = 32'h6000_0100;
    modelRequest(32'h6000_0040, 1'b0);
    imem_addr  = 32'h6000_0040;
    imem_rmask = 4'hF;
    waitResp(lat);
    imem_rmask = 4'h0;
    checkOutput("flush_consumed", 32'(flush_beat), 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-fill");
    grant_delay = 2;
    beat_limit  = 2;
    modelRequest(32'h6000_0200, 1'b0);
    imem_addr  = 32'h6000_0200;
    imem_rmask = 4'hF;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bmem_read && w < 20);
    checkOutput("miss_req_seen", {31'b0, bmem_read}, 32'd1);
    if (bmem_read) serveBurst();
    beat_limit = BURST_LEN;
    rst        = 1'b0;
    imem_rmask = 4'h0;
    #1;
    checkOutput("midrst_bmem_read",  {31'b0, bmem_read}, 32'd0);
    checkOutput("midrst_imem_resp",  {31'b0, imem_resp}, 32'd0);
    checkOutput("midrst_imem_rdata", imem_rdata, 32'd0);
    checkOutput("midrst_bmem_addr",  bmem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst          = 1'b1;
    model_valid  = 1'b0;
    model_hits   = 0;
    model_misses = 0;
    for (int k = 2; k < BURST_LEN; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = mem_beat(32'h6000_0200, k);
      @(negedge clk);
      checkOutput("stray_no_read", {31'b0, bmem_read}, 32'd0);
      checkOutput("stray_no_resp", {31'b0, imem_resp}, 32'd0);
    end
    bmem_rvalid = 1'b0;
    applyStimulus(32'h6000_0204, 4'hF, lat);
    imem_rmask = 4'h0;

    repeat (3) @(negedge clk);
    checkOutput("word_q_drained", 32'(exp_word_q.size()), 32'd0);
    checkOutput("bmem_q_drained", 32'(exp_bmem_q.size()), 32'd0);
`ifdef IMEM_PERF_CNT_EN
    checkOutput("hit_count",  hit_count,  32'(model_hits));
    checkOutput("miss_count", miss_count, 32'(model_misses));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
